// File: rtl/umi_mux.sv
`default_nettype none
// ============================================================================
// Module      : umi_mux
// Description : N-to-1 UMI multiplexer. Zero-latency one-hot select of the
//               granted input onto the output, with fixed-priority or
//               round-robin arbitration, packet locking on EOM (cmd bit 22)
//               and grant hold while the output is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module umi_mux #(
    parameter int N  = 4,
    parameter int DW = 256,
    parameter int CW = 32,
    parameter int AW = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      arbmode,
    input  logic [N-1:0]    arbmask,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready
);

    localparam int c_PW      = (N > 1) ? $clog2(N) : 1;
    localparam int c_EOM_BIT = 22;

    // Registered arbitration state
    logic [c_PW-1:0] r_ptr;      // round-robin start index
    logic [N-1:0]    r_grant;    // grant remembered for lock / stall hold
    logic            r_lock;     // mid-packet: grant pinned to r_grant
    logic            r_hold;     // output stalled last cycle: grant pinned

    logic [N-1:0]    w_eligible;
    logic [N-1:0]    w_fp_grant;
    logic [N-1:0]    w_rr_grant;
    logic            w_fp_found;
    logic            w_rr_found;
    logic            w_rr_mode;
    logic [N-1:0]    w_grant;
    logic [N-1:0]    w_sel;
    logic [c_PW-1:0] w_grant_idx;
    logic            w_xfer;
    logic            w_eom;
    logic [CW-1:0]   w_cmd;
    logic [AW-1:0]   w_dst;
    logic [AW-1:0]   w_src;
    logic [DW-1:0]   w_data;

    assign w_eligible = umi_in_valid & ~arbmask;
    assign w_rr_mode  = (arbmode == 2'b01) || (arbmode == 2'b10);

    // Fixed priority: lowest eligible index wins
    always_comb begin
        w_fp_grant = '0;
        w_fp_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_fp_found && w_eligible[i]) begin
                w_fp_grant[i] = 1'b1;
                w_fp_found    = 1'b1;
            end
        end
    end

    // Round-robin: first eligible index scanning r_ptr, r_ptr+1, ... mod N
    always_comb begin
        w_rr_grant = '0;
        w_rr_found = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_rr_found && w_eligible[i] &&
                    (((int'(r_ptr) + off) % N) == i)) begin
                    w_rr_grant[i] = 1'b1;
                    w_rr_found    = 1'b1;
                end
            end
        end
    end

    // Final grant: pinned while locked or stalled, fresh arbitration
    // otherwise; forced idle during reset since the path is combinational
    always_comb begin
        if (reset) begin
            w_grant = '0;
        end else if (r_lock || r_hold) begin
            w_grant = r_grant;
        end else if (w_rr_mode) begin
            w_grant = w_rr_grant;
        end else begin
            w_grant = w_fp_grant;
        end
    end

    // One-hot grant to index, used to advance the round-robin pointer
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = c_PW'(i);
            end
        end
    end

    // AND-OR select of the granted input; all fields zero when not valid
    always_comb begin
        w_cmd  = '0;
        w_dst  = '0;
        w_src  = '0;
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            w_cmd  = w_cmd  | (umi_in_cmd[i*CW +: CW]     & {CW{w_sel[i]}});
            w_dst  = w_dst  | (umi_in_dstaddr[i*AW +: AW] & {AW{w_sel[i]}});
            w_src  = w_src  | (umi_in_srcaddr[i*AW +: AW] & {AW{w_sel[i]}});
            w_data = w_data | (umi_in_data[i*DW +: DW]    & {DW{w_sel[i]}});
        end
    end

    // A locked grant whose source has dropped valid presents nothing
    assign w_sel           = w_grant & umi_in_valid;
    assign umi_out_valid   = |w_sel;
    assign umi_in_ready    = w_grant & {N{umi_out_ready}};
    assign umi_out_cmd     = w_cmd;
    assign umi_out_dstaddr = w_dst;
    assign umi_out_srcaddr = w_src;
    assign umi_out_data    = w_data;
    assign w_xfer          = umi_out_valid & umi_out_ready;
    assign w_eom           = w_cmd[c_EOM_BIT];

    // Lock, stall-hold and round-robin pointer bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_lock  <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_grant <= w_grant;
            r_hold  <= umi_out_valid & ~umi_out_ready;
            if (w_xfer) begin
                r_lock <= ~w_eom;
                if (w_eom && w_rr_mode) begin
                    r_ptr <= c_PW'((int'(w_grant_idx) + 1) % N);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_umi_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_umi_mux
// Description : Self-checking bench for umi_mux: directed vector table,
//               lock / stall / reset-mid-lock sequences and random traffic
//               from four packet sources with a per-source scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_umi_mux;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int CW   = 32;
    localparam int AW   = 16;
    localparam int NPKT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      arbmode;
    logic [N-1:0]    arbmask;
    logic [N-1:0]    umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    umi_mux #(.N(N), .DW(DW), .CW(CW), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .arbmode         (arbmode),
        .arbmask         (arbmask),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready)
    );

    // Beat field encodings: every field identifies source and tag
    function automatic logic [CW-1:0] f_cmd(int s, logic eom, int tag);
        return (CW'(eom) << 22) | (CW'(s) << 16) | CW'(tag & 16'hFFFF);
    endfunction

    function automatic logic [DW-1:0] f_data(int s, int tag);
        return 32'hA500_0000 | (DW'(s) << 16) | DW'(tag & 16'hFFFF);
    endfunction

    function automatic logic [AW-1:0] f_dst(int s, int tag);
        return AW'(16'h1000 + s * 256 + (tag & 255));
    endfunction

    function automatic logic [AW-1:0] f_src(int s);
        return AW'(16'hC000 + s);
    endfunction

    function automatic int f_len(int s, int p);
        return ((s + p) % 3) + 1;
    endfunction

    task automatic drive_src(int s, logic v, logic eom, int tag);
        umi_in_valid[s]            = v;
        umi_in_cmd[s*CW +: CW]     = f_cmd(s, eom, tag);
        umi_in_dstaddr[s*AW +: AW] = f_dst(s, tag);
        umi_in_srcaddr[s*AW +: AW] = f_src(s);
        umi_in_data[s*DW +: DW]    = f_data(s, tag);
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Full output check: src < 0 means nothing should be presented
    task automatic check_beat(string name, int src, int tag, logic eom);
        logic [N-1:0] exp_rdy;
        exp_rdy = (src >= 0 && umi_out_ready) ? N'(1 << src) : '0;
        check({name, "_ready"}, umi_in_ready, exp_rdy);
        if (src < 0) begin
            check({name, "_valid"}, umi_out_valid, 0);
            check({name, "_data"}, umi_out_data, 0);
            check({name, "_cmd"}, umi_out_cmd, 0);
        end else begin
            check({name, "_valid"}, umi_out_valid, 1);
            check({name, "_data"}, umi_out_data, f_data(src, tag));
            check({name, "_cmd"}, umi_out_cmd, f_cmd(src, eom, tag));
            check({name, "_dst"}, umi_out_dstaddr, f_dst(src, tag));
            check({name, "_srcaddr"}, umi_out_srcaddr, f_src(src));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] mask;
        logic [3:0] valid;
        logic       ordy;
        int         exp_src;
    } vec_t;

    vec_t vecs[18];

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int           pkt [N];
        int           beat[N];
        logic         v   [N];
        int           cur_src;
        int           s;
        logic [N-1:0] xfer;
        logic         all_done;
        logic         eom;

        // Single-beat (EOM=1) vectors, ready high unless noted; pointer
        // history tracked by hand in the comments
        vecs[0]  = '{2'b00, 4'b0000, 4'b0000, 1'b1, -1};
        vecs[1]  = '{2'b00, 4'b0000, 4'b1010, 1'b1,  1};
        vecs[2]  = '{2'b00, 4'b0000, 4'b1000, 1'b1,  3};
        vecs[3]  = '{2'b11, 4'b0000, 4'b1100, 1'b1,  2};
        vecs[4]  = '{2'b00, 4'b0001, 4'b0011, 1'b1,  1};
        vecs[5]  = '{2'b00, 4'b1111, 4'b1111, 1'b1, -1};
        vecs[6]  = '{2'b00, 4'b0000, 4'b0110, 1'b1,  1};
        vecs[7]  = '{2'b10, 4'b0000, 4'b1111, 1'b1,  0};   // P 0 -> 1
        vecs[8]  = '{2'b10, 4'b0000, 4'b1111, 1'b1,  1};   // P 1 -> 2
        vecs[9]  = '{2'b01, 4'b0000, 4'b1111, 1'b1,  2};   // P 2 -> 3
        vecs[10] = '{2'b10, 4'b0000, 4'b1111, 1'b1,  3};   // P 3 -> 0
        vecs[11] = '{2'b10, 4'b0000, 4'b1111, 1'b1,  0};   // P 0 -> 1
        vecs[12] = '{2'b10, 4'b0000, 4'b0001, 1'b1,  0};   // wraps, P stays 1
        vecs[13] = '{2'b10, 4'b0010, 4'b0011, 1'b1,  0};   // 1 masked, P 1
        vecs[14] = '{2'b10, 4'b0000, 4'b1100, 1'b1,  2};   // P 1 -> 3
        vecs[15] = '{2'b00, 4'b0000, 4'b1111, 1'b1,  0};   // fixed, P stays 3
        vecs[16] = '{2'b10, 4'b0000, 4'b0111, 1'b1,  0};   // P 3 -> 1
        vecs[17] = '{2'b00, 4'b0000, 4'b0000, 1'b0, -1};

        // Reset with every input valid: nothing may be presented
        reset          = 1'b1;
        arbmode        = 2'b00;
        arbmask        = '0;
        umi_out_ready  = 1'b1;
        umi_in_valid   = '0;
        umi_in_cmd     = '0;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = '0;
        umi_in_data    = '0;
        for (int i = 0; i < N; i++) drive_src(i, 1'b1, 1'b1, 0);
        @(negedge clk);
        check("rst_valid", umi_out_valid, 0);
        check("rst_ready", umi_in_ready, 0);
        check("rst_data", umi_out_data, 0);
        next_cycle();
        reset = 1'b0;

        // Directed vector table
        for (int k = 0; k < 18; k++) begin
            arbmode       = vecs[k].mode;
            arbmask       = vecs[k].mask;
            umi_out_ready = vecs[k].ordy;
            for (int i = 0; i < N; i++) drive_src(i, vecs[k].valid[i], 1'b1, k);
            @(negedge clk);
            check_beat($sformatf("vec%0d", k), vecs[k].exp_src, k, 1'b1);
            next_cycle();
        end

        // Lock: 3-beat packet from input 2 while input 0 stays valid
        umi_out_ready = 1'b1;
        arbmode       = 2'b00;
        arbmask       = 4'b0001;
        for (int i = 0; i < N; i++) drive_src(i, 1'b0, 1'b1, 0);
        drive_src(0, 1'b1, 1'b1, 100);
        drive_src(2, 1'b1, 1'b0, 200);
        @(negedge clk);
        check_beat("lock_b0", 2, 200, 1'b0);
        next_cycle();
        arbmask = 4'b0000;
        drive_src(2, 1'b1, 1'b0, 201);
        @(negedge clk);
        check_beat("lock_b1", 2, 201, 1'b0);
        next_cycle();
        arbmode = 2'b10;
        drive_src(2, 1'b0, 1'b0, 202);
        @(negedge clk);
        check("lock_gap_valid", umi_out_valid, 0);
        check("lock_gap_ready_others", umi_in_ready & 4'b1011, 0);
        check("lock_gap_data", umi_out_data, 0);
        next_cycle();
        drive_src(2, 1'b1, 1'b1, 202);
        @(negedge clk);
        check_beat("lock_b2", 2, 202, 1'b1);
        next_cycle();
        arbmode = 2'b00;
        drive_src(2, 1'b1, 1'b1, 203);
        @(negedge clk);
        check_beat("lock_after", 0, 100, 1'b1);
        next_cycle();

        // Stall: input 0 presented with ready low for 5 cycles; input 1
        // raised and input 0 masked meanwhile must not move the grant
        drive_src(2, 1'b0, 1'b1, 0);
        drive_src(0, 1'b1, 1'b1, 300);
        umi_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                drive_src(1, 1'b1, 1'b1, 301);
                arbmask = 4'b0001;
            end
            @(negedge clk);
            check_beat($sformatf("stall%0d", c), 0, 300, 1'b1);
            next_cycle();
        end
        umi_out_ready = 1'b1;
        @(negedge clk);
        check_beat("stall_release", 0, 300, 1'b1);
        next_cycle();
        arbmask = 4'b0000;
        drive_src(0, 1'b0, 1'b1, 0);
        @(negedge clk);
        check_beat("stall_next", 1, 301, 1'b1);
        next_cycle();

        // Reset in the middle of a locked packet from input 3
        for (int i = 0; i < N; i++) drive_src(i, 1'b0, 1'b1, 0);
        drive_src(3, 1'b1, 1'b0, 400);
        @(negedge clk);
        check_beat("rlock_b0", 3, 400, 1'b0);
        next_cycle();
        reset = 1'b1;
        drive_src(3, 1'b1, 1'b0, 401);
        drive_src(1, 1'b1, 1'b1, 402);
        @(negedge clk);
        check("rlock_rst_valid", umi_out_valid, 0);
        check("rlock_rst_ready", umi_in_ready, 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_beat("rlock_fresh", 1, 402, 1'b1);
        next_cycle();

        // Random traffic: 4 sources, random ready and arbmode
        cur_src = -1;
        for (int i = 0; i < N; i++) begin
            pkt[i]  = 0;
            beat[i] = 0;
            v[i]    = 1'b0;
        end
        all_done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !all_done; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && pkt[i] < NPKT && $urandom_range(0, 3) != 0) v[i] = 1'b1;
                drive_src(i, v[i], beat[i] == f_len(i, pkt[i]) - 1,
                          pkt[i] * 16 + beat[i]);
            end
            umi_out_ready = ($urandom_range(0, 3) != 0);
            arbmode       = 2'($urandom_range(0, 3));
            @(negedge clk);
            xfer = umi_in_ready & umi_in_valid;
            check("rnd_one_xfer", $countones(xfer) <= 1, 1);
            check("rnd_xfer_vs_out", (umi_out_valid & umi_out_ready), (xfer != 0));
            if (xfer != 0) begin
                s = 0;
                for (int i = 0; i < N; i++) if (xfer[i]) s = i;
                eom = (beat[s] == f_len(s, pkt[s]) - 1);
                check("rnd_data", umi_out_data, f_data(s, pkt[s] * 16 + beat[s]));
                check("rnd_cmd", umi_out_cmd, f_cmd(s, eom, pkt[s] * 16 + beat[s]));
                if (cur_src >= 0) check("rnd_no_interleave", s, cur_src);
                v[s] = 1'b0;
                if (eom) begin
                    cur_src = -1;
                    beat[s] = 0;
                    pkt[s]++;
                end else begin
                    cur_src = s;
                    beat[s]++;
                end
            end
            all_done = 1'b1;
            for (int i = 0; i < N; i++) if (pkt[i] < NPKT) all_done = 1'b0;
            next_cycle();
        end
        check("rnd_all_delivered", all_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
